// File: rtl/sdram_resp.sv
// Behavioural SDRAM device responder: decodes the command bus, keeps a small
// backing store, returns read data at CAS latency and flags protocol misuse.
module sdram_resp #(
   parameter int ROW_BITS = 4,
   parameter int COL_BITS = 6,
   parameter int RCD      = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        sdram_ncs,
   input  logic        sdram_nras,
   input  logic        sdram_ncas,
   input  logic        sdram_nwe,
   input  logic [12:0] sdram_a,
   input  logic [1:0]  sdram_ba,
   input  logic        sdram_dqml,
   input  logic        sdram_dqmh,
   input  logic [15:0] dq_in,
   output logic [15:0] dq_out,
   output logic        dq_oe,
   output logic        err,
   output logic [2:0]  err_code,
   output logic [15:0] rfs_count
);
   localparam int IDX_W = 2 + ROW_BITS + COL_BITS;
   localparam int DEPTH = 1 << IDX_W;
   localparam logic [7:0] RCD_SAT = 8'(RCD);

   typedef enum logic [2:0] {
      CMD_NOP, CMD_ACT, CMD_RD, CMD_WR, CMD_PRE, CMD_REF, CMD_LMR
   } cmd_t;

   logic [15:0]         r_mem [DEPTH];
   logic [ROW_BITS-1:0] r_row [4];
   logic [7:0]          r_rcd [4];
   logic [3:0]          r_open;
   logic                r_ap_pend;
   logic [1:0]          r_ap_bank;
   logic                r_mode_valid;
   logic [2:0]          r_cas;
   logic [2:1]          r_vld_pipe;
   logic [15:0]         r_dat2, r_dat1;
   logic [15:0]         r_dq_out;
   logic                r_dq_oe;
   logic                r_err;
   logic [2:0]          r_err_code;
   logic [15:0]         r_rfs;

   cmd_t             w_cmd;
   logic [3:0]       w_ap_mask, w_open, w_open_nxt;
   logic             w_bank_open, w_rd, w_wr, w_access, w_rd_cl2;
   logic [IDX_W-1:0] w_idx;
   logic [15:0]      w_rdata;
   logic [2:0]       w_code;
   logic             w_unused;

   always_comb begin
      w_cmd = CMD_NOP;
      if (!sdram_ncs) begin
         case ({sdram_nras, sdram_ncas, sdram_nwe})
            3'b011:  w_cmd = CMD_ACT;
            3'b101:  w_cmd = CMD_RD;
            3'b100:  w_cmd = CMD_WR;
            3'b010:  w_cmd = CMD_PRE;
            3'b001:  w_cmd = CMD_REF;
            3'b000:  w_cmd = CMD_LMR;
            default: w_cmd = CMD_NOP;
         endcase
      end
   end

   // An auto-precharge issued last edge closes its bank before this edge's command is judged.
   assign w_ap_mask   = r_ap_pend ? (4'b0001 << r_ap_bank) : 4'b0000;
   assign w_open      = r_open & ~w_ap_mask;
   assign w_bank_open = w_open[sdram_ba];
   assign w_rd        = (w_cmd == CMD_RD);
   assign w_wr        = (w_cmd == CMD_WR);
   assign w_access    = (w_rd || w_wr) && w_bank_open && r_mode_valid;
   assign w_rd_cl2    = w_rd && w_access && (r_cas == 3'd2);
   assign w_idx       = {sdram_ba, r_row[sdram_ba], sdram_a[COL_BITS-1:0]};
   assign w_rdata     = r_mem[w_idx];
   assign w_unused    = ^sdram_a;

   // Checks are ordered so the lowest applicable code wins.
   always_comb begin
      w_code     = 3'd0;
      w_open_nxt = w_open;
      case (w_cmd)
         CMD_LMR: if (sdram_a[2:0] != 3'd0 ||
                      (sdram_a[6:4] != 3'd2 && sdram_a[6:4] != 3'd3)) w_code = 3'd1;
         CMD_ACT: begin
            if (w_bank_open) w_code = 3'd2;
            w_open_nxt[sdram_ba] = 1'b1;
         end
         CMD_RD, CMD_WR: begin
            if (!w_bank_open)                    w_code = 3'd3;
            else if (!r_mode_valid)              w_code = 3'd4;
            else if (r_rcd[sdram_ba] < RCD_SAT)  w_code = 3'd5;
         end
         CMD_PRE: begin
            if (sdram_a[10]) w_open_nxt = 4'b0000;
            else             w_open_nxt[sdram_ba] = 1'b0;
         end
         CMD_REF: if (|w_open) w_code = 3'd6;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_open       <= 4'b0000;
         r_ap_pend    <= 1'b0;
         r_ap_bank    <= 2'd0;
         r_mode_valid <= 1'b0;
         r_cas        <= 3'd3;
         r_vld_pipe   <= 2'b00;
         r_dat2       <= 16'h0000;
         r_dat1       <= 16'h0000;
         r_dq_out     <= 16'h0000;
         r_dq_oe      <= 1'b0;
         r_err        <= 1'b0;
         r_err_code   <= 3'd0;
         r_rfs        <= 16'h0000;
         for (int b = 0; b < 4; b++) r_rcd[b] <= 8'd0;
      end else begin
         r_open    <= w_open_nxt;
         r_ap_pend <= w_access && sdram_a[10];
         r_ap_bank <= sdram_ba;
         for (int b = 0; b < 4; b++) begin
            if (w_cmd == CMD_ACT && sdram_ba == 2'(b)) r_rcd[b] <= 8'd1;
            else if (r_rcd[b] < RCD_SAT)               r_rcd[b] <= r_rcd[b] + 8'd1;
         end
         if (w_cmd == CMD_ACT) r_row[sdram_ba] <= sdram_a[ROW_BITS-1:0];
         if (w_cmd == CMD_LMR) begin
            r_cas        <= sdram_a[6:4];
            r_mode_valid <= 1'b1;
         end
         // CL3 reads enter stage 2, CL2 reads enter stage 1; a newer entry wins stage 1.
         r_vld_pipe[2] <= w_rd && w_access && (r_cas != 3'd2);
         r_dat2        <= w_rdata;
         r_vld_pipe[1] <= w_rd_cl2 || r_vld_pipe[2];
         r_dat1        <= w_rd_cl2 ? w_rdata : r_dat2;
         r_dq_oe       <= r_vld_pipe[1];
         if (r_vld_pipe[1]) r_dq_out <= r_dat1;
         if (!r_err && w_code != 3'd0) begin
            r_err      <= 1'b1;
            r_err_code <= w_code;
         end
         if (w_cmd == CMD_REF) r_rfs <= r_rfs + 16'd1;
      end
   end

   // Store is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk) begin
      if (!reset && w_wr && w_access) begin
         if (!sdram_dqml) r_mem[w_idx][7:0]  <= dq_in[7:0];
         if (!sdram_dqmh) r_mem[w_idx][15:8] <= dq_in[15:8];
      end
   end

   assign dq_out    = r_dq_out;
   assign dq_oe     = r_dq_oe;
   assign err       = r_err;
   assign err_code  = r_err_code;
   assign rfs_count = r_rfs;
endmodule

// File: tb/tb_sdram_resp.sv
// Self-checking bench for sdram_resp: directed protocol scenarios plus
// randomized command traffic against a transaction-level device model.
module tb_sdram_resp;
  localparam int ROW_BITS = 4;
  localparam int COL_BITS = 6;
  localparam int RCD      = 2;
  localparam logic [2:0] C_NOP = 3'b111, C_ACT = 3'b011, C_RD = 3'b101, C_WR = 3'b100,
                         C_PRE = 3'b010, C_REF = 3'b001, C_LMR = 3'b000;

  logic clk = 1'b0;
  logic reset, sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe, sdram_dqml, sdram_dqmh;
  logic [12:0] sdram_a;
  logic [1:0]  sdram_ba;
  logic [15:0] dq_in, dq_out, rfs_count;
  logic dq_oe, err;
  logic [2:0] err_code;

  sdram_resp #(.ROW_BITS(ROW_BITS), .COL_BITS(COL_BITS), .RCD(RCD)) dut (
    .clk(clk), .reset(reset), .sdram_ncs(sdram_ncs), .sdram_nras(sdram_nras),
    .sdram_ncas(sdram_ncas), .sdram_nwe(sdram_nwe), .sdram_a(sdram_a), .sdram_ba(sdram_ba),
    .sdram_dqml(sdram_dqml), .sdram_dqmh(sdram_dqmh), .dq_in(dq_in), .dq_out(dq_out),
    .dq_oe(dq_oe), .err(err), .err_code(err_code), .rfs_count(rfs_count));

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int edge_no = 0;

  // Device model: bank state by edge number, byte-wise memory, reads scheduled by output edge.
  bit   m_open[4];
  int   m_row[4], m_act[4], m_apc[4];
  bit   m_mode, m_err;
  int   m_cas, m_code, m_rfs;
  logic [7:0]  m_lo[int], m_hi[int];
  logic [15:0] m_sched[int];
  bit          m_sknown[int];
  logic [15:0] m_dq;
  bit          m_dqk, e_oe;

  task automatic model_edge();
    int e, b, idx, code;
    bit k, any;
    logic [2:0] rcw;
    e = edge_no;
    if (reset) begin
      for (int i = 0; i < 4; i++) begin m_open[i] = 0; m_apc[i] = -1; end
      m_mode = 0; m_cas = 3; m_err = 0; m_code = 0; m_rfs = 0;
      m_sched.delete(); m_sknown.delete();
      m_dq = 16'h0; m_dqk = 1; e_oe = 0;
      return;
    end
    for (int i = 0; i < 4; i++) if (m_apc[i] == e) begin m_open[i] = 0; m_apc[i] = -1; end
    b = int'(sdram_ba); code = 0;
    rcw = sdram_ncs ? C_NOP : {sdram_nras, sdram_ncas, sdram_nwe};
    case (rcw)
      C_LMR: begin
        m_cas = int'(sdram_a[6:4]); m_mode = 1;
        if (sdram_a[2:0] != 0 || (m_cas != 2 && m_cas != 3)) code = 1;
      end
      C_ACT: begin
        if (m_open[b]) code = 2;
        m_open[b] = 1; m_row[b] = int'(sdram_a); m_act[b] = e;
      end
      C_RD, C_WR: begin
        if (!m_open[b]) code = 3;
        else if (!m_mode) code = 4;
        else begin
          if (e - m_act[b] < RCD) code = 5;
          idx = b * (1 << (ROW_BITS + COL_BITS)) + (m_row[b] % (1 << ROW_BITS)) * (1 << COL_BITS)
                + int'(sdram_a[8:0]) % (1 << COL_BITS);
          if (rcw == C_WR) begin
            if (!sdram_dqml) m_lo[idx] = dq_in[7:0];
            if (!sdram_dqmh) m_hi[idx] = dq_in[15:8];
          end else begin
            k = m_lo.exists(idx) && m_hi.exists(idx);
            m_sknown[e + m_cas - 1] = k;
            if (k) m_sched[e + m_cas - 1] = {m_hi[idx], m_lo[idx]};
            else   m_sched[e + m_cas - 1] = 16'h0;
          end
          if (sdram_a[10]) m_apc[b] = e + 1;
        end
      end
      C_PRE: begin
        if (sdram_a[10]) for (int i = 0; i < 4; i++) m_open[i] = 0;
        else m_open[b] = 0;
      end
      C_REF: begin
        m_rfs = (m_rfs + 1) % 65536;
        any = 0;
        for (int i = 0; i < 4; i++) any |= m_open[i];
        if (any) code = 6;
      end
      default: ;
    endcase
    if (code != 0 && !m_err) begin m_err = 1; m_code = code; end
    if (m_sched.exists(e)) begin
      e_oe = 1; m_dq = m_sched[e]; m_dqk = m_sknown[e];
      m_sched.delete(e); m_sknown.delete(e);
    end else e_oe = 0;
  endtask

  // Advance one clock: model consumes the pins sampled at this edge; outputs read at negedge.
  task automatic tick();
    model_edge();
    @(posedge clk);
    edge_no++;
    @(negedge clk);
    sdram_ncs = 1'b1; {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
    sdram_dqml = 1'b0; sdram_dqmh = 1'b0;
  endtask

  task automatic issue(input logic [2:0] rcw, input logic [1:0] b, input logic [12:0] addr,
                       input logic [15:0] d = 16'h0, input logic ml = 1'b0, input logic mh = 1'b0);
    sdram_ncs = 1'b0; {sdram_nras, sdram_ncas, sdram_nwe} = rcw;
    sdram_ba = b; sdram_a = addr; dq_in = d; sdram_dqml = ml; sdram_dqmh = mh;
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1; tick(); reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL reset_oe got=%b exp=0", dq_oe); end
    checks++; if (dq_out !== 16'h0) begin failures++; $display("FAIL reset_dq got=%h exp=0000", dq_out); end
    checks++; if (err !== 1'b0 || err_code !== 3'd0) begin failures++; $display("FAIL reset_err got=%b/%0d exp=0/0", err, err_code); end
    checks++; if (rfs_count !== 16'h0) begin failures++; $display("FAIL reset_rfs got=%0d exp=0", rfs_count); end
  endtask

  task automatic test_basic_rw();
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_ACT, 2'd1, 13'd5);
    tick(); tick();
    issue(C_WR, 2'd1, 13'd3, 16'hBEEF);
    issue(C_RD, 2'd1, 13'd3);
    checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL basic_oe_n0 got=%b exp=0", dq_oe); end
    tick();
    checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL basic_oe_n1 got=%b exp=0", dq_oe); end
    tick();
    checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hBEEF) begin failures++; $display("FAIL basic_data got=%b/%h exp=1/beef", dq_oe, dq_out); end
    tick();
    checks++; if (dq_oe !== 1'b0 || dq_out !== 16'hBEEF) begin failures++; $display("FAIL basic_release got=%b/%h exp=0/beef", dq_oe, dq_out); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL basic_err got=%b exp=0", err); end
  endtask

  task automatic test_byte_mask();
    issue(C_WR, 2'd1, 13'd3, 16'h1234, 1'b1, 1'b0);
    issue(C_RD, 2'd1, 13'd3);
    tick(); tick();
    checks++; if (dq_oe !== 1'b1 || dq_out !== 16'h12EF) begin failures++; $display("FAIL byte_mask got=%b/%h exp=1/12ef", dq_oe, dq_out); end
  endtask

  task automatic test_closed_bank();
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_RD, 2'd0, 13'd0);
    checks++; if (err !== 1'b1 || err_code !== 3'd3) begin failures++; $display("FAIL closed_err got=%b/%0d exp=1/3", err, err_code); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL closed_oe cyc%0d got=%b exp=0", i, dq_oe); end
      tick();
    end
  endtask

  task automatic test_rcd();
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_ACT, 2'd2, 13'd1);
    tick(); tick();
    issue(C_WR, 2'd2, 13'd7, 16'hA5A5);
    issue(C_PRE, 2'd2, 13'd0);
    issue(C_ACT, 2'd2, 13'd1);
    issue(C_RD, 2'd2, 13'd7);
    checks++; if (err !== 1'b1 || err_code !== 3'd5) begin failures++; $display("FAIL rcd_err got=%b/%0d exp=1/5", err, err_code); end
    tick(); tick();
    checks++; if (dq_oe !== 1'b1 || dq_out !== 16'hA5A5) begin failures++; $display("FAIL rcd_data got=%b/%h exp=1/a5a5", dq_oe, dq_out); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] d[4];
    do_reset();
    issue(C_LMR, 2'd0, 13'h020);
    issue(C_ACT, 2'd0, 13'd3);
    tick(); tick();
    for (int i = 0; i < 4; i++) begin
      d[i] = 16'($urandom);
      issue(C_WR, 2'd0, 13'(i), d[i]);
    end
    issue(C_RD, 2'd0, 13'd0);
    checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL b2b_first got=%b exp=0", dq_oe); end
    for (int i = 1; i < 5; i++) begin
      if (i < 4) issue(C_RD, 2'd0, 13'(i)); else tick();
      checks++; if (dq_oe !== 1'b1 || dq_out !== d[i-1]) begin failures++; $display("FAIL b2b_word%0d got=%b/%h exp=1/%h", i - 1, dq_oe, dq_out, d[i-1]); end
    end
    tick();
    checks++; if (dq_oe !== 1'b0 || err !== 1'b0) begin failures++; $display("FAIL b2b_end got=%b/%b exp=0/0", dq_oe, err); end
  endtask

  task automatic test_reset_inflight();
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_ACT, 2'd3, 13'd0);
    tick(); tick();
    issue(C_RD, 2'd3, 13'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (dq_oe !== 1'b0) begin failures++; $display("FAIL inflight_oe cyc%0d got=%b exp=0", i, dq_oe); end
      tick();
    end
    repeat (3) issue(C_REF, 2'd0, 13'd0);
    checks++; if (rfs_count !== 16'd3 || err !== 1'b0) begin failures++; $display("FAIL refresh got=%0d/%b exp=3/0", rfs_count, err); end
  endtask

  task automatic test_err_codes();
    do_reset();
    issue(C_LMR, 2'd0, 13'h031);
    checks++; if (err_code !== 3'd1) begin failures++; $display("FAIL code_bl got=%0d exp=1", err_code); end
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_ACT, 2'd0, 13'd1);
    issue(C_ACT, 2'd0, 13'd2);
    checks++; if (err_code !== 3'd2) begin failures++; $display("FAIL code_reopen got=%0d exp=2", err_code); end
    do_reset();
    issue(C_RD, 2'd1, 13'd0);
    checks++; if (err_code !== 3'd3) begin failures++; $display("FAIL code_lowest got=%0d exp=3", err_code); end
    do_reset();
    issue(C_ACT, 2'd1, 13'd0);
    tick(); tick();
    issue(C_WR, 2'd1, 13'd0, 16'h5555);
    checks++; if (err_code !== 3'd4) begin failures++; $display("FAIL code_nomode got=%0d exp=4", err_code); end
    do_reset();
    issue(C_ACT, 2'd0, 13'd0);
    issue(C_REF, 2'd0, 13'd0);
    issue(C_PRE, 2'd0, 13'd0);
    issue(C_RD, 2'd2, 13'd0);
    checks++; if (err !== 1'b1 || err_code !== 3'd6) begin failures++; $display("FAIL code_sticky got=%b/%0d exp=1/6", err, err_code); end
    // auto-precharge and precharge-all both leave every bank closed
    do_reset();
    issue(C_LMR, 2'd0, 13'h030);
    issue(C_ACT, 2'd0, 13'd2);
    tick(); tick();
    issue(C_WR, 2'd0, 13'h405, 16'h7777);
    issue(C_ACT, 2'd0, 13'd2);
    issue(C_ACT, 2'd1, 13'd2);
    issue(C_PRE, 2'd3, 13'h400);
    issue(C_REF, 2'd0, 13'd0);
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL precharge got=%b/%0d exp=0/0", err, err_code); end
  endtask

  task automatic test_random();
    int r;
    logic [12:0] addr;
    for (int round = 0; round < 2; round++) begin
      do_reset();
      issue(C_LMR, 2'd0, ($urandom_range(1) != 0) ? 13'h020 : 13'h030);
      for (int i = 0; i < 300; i++) begin
        r = $urandom_range(99);
        addr = {2'b00, 1'($urandom_range(7) == 0), 1'b0, 3'($urandom), 3'($urandom_range(7))};
        if (r < 15) tick();
        else if (r < 25) issue(($urandom_range(1) != 0) ? 3'b110 : C_NOP, 2'($urandom), 13'($urandom));
        else if (r < 38) issue(C_ACT, 2'($urandom), (13'($urandom) & 13'h1FF0) | 13'($urandom_range(1)));
        else if (r < 60) issue(C_WR, 2'($urandom), addr, 16'($urandom), 1'($urandom_range(3) == 0), 1'($urandom_range(3) == 0));
        else if (r < 82) issue(C_RD, 2'($urandom), addr, 16'($urandom), 1'($urandom), 1'($urandom));
        else if (r < 92) issue(C_PRE, 2'($urandom), ($urandom_range(3) == 0) ? 13'h400 : 13'h000);
        else if (r < 96) issue(C_REF, 2'd0, 13'd0);
        else issue(C_LMR, 2'd0, ($urandom_range(1) != 0) ? 13'h020 : 13'h030);
        checks++; if (dq_oe !== e_oe) begin failures++; $display("FAIL rand_oe edge%0d got=%b exp=%b", edge_no, dq_oe, e_oe); end
        if (m_dqk) begin
          checks++; if (dq_out !== m_dq) begin failures++; $display("FAIL rand_dq edge%0d got=%h exp=%h", edge_no, dq_out, m_dq); end
        end
        checks++; if (err !== m_err || err_code !== 3'(m_code)) begin failures++; $display("FAIL rand_err edge%0d got=%b/%0d exp=%b/%0d", edge_no, err, err_code, m_err, m_code); end
        checks++; if (rfs_count !== 16'(m_rfs)) begin failures++; $display("FAIL rand_rfs edge%0d got=%0d exp=%0d", edge_no, rfs_count, m_rfs); end
      end
    end
  endtask

  initial begin
    reset = 1'b1; sdram_ncs = 1'b1; {sdram_nras, sdram_ncas, sdram_nwe} = C_NOP;
    sdram_a = '0; sdram_ba = '0; sdram_dqml = 1'b0; sdram_dqmh = 1'b0; dq_in = '0;
    @(negedge clk);
    test_reset();
    test_basic_rw();
    test_byte_mask();
    test_closed_bank();
    test_rcd();
    test_back_to_back();
    test_reset_inflight();
    test_err_codes();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sdram_resp.md
SDRAM_RESP -- requirements
Module: sdram_resp

Interface
REQ-001 SHALL have parameter ROW_BITS, default 4: low row-address bits kept in backing store.
REQ-002 SHALL have parameter COL_BITS, default 6: low column-address bits kept in backing store.
REQ-003 SHALL have parameter RCD, default 2: minimum cycles from ACTIVE to READ/WRITE on the same bank.
REQ-004 SHALL have port clk  in  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port reset  in  1: synchronous, active-high reset.
REQ-006 SHALL have ports sdram_ncs, sdram_nras, sdram_ncas, sdram_nwe  in  1 each: command strobes, active-low.
REQ-007 SHALL have ports sdram_a  in  13 and sdram_ba  in  2: multiplexed address and bank.
REQ-008 SHALL have ports sdram_dqml, sdram_dqmh  in  1 each: write byte masks, 1 = masked.
REQ-009 SHALL have port dq_in  in  16: write data from the bus.
REQ-010 SHALL have port dq_out  out  16: read data driven onto the bus.
REQ-011 SHALL have port dq_oe  out  1: dq_out drive enable.
REQ-012 SHALL have port err  out  1: sticky protocol-violation flag.
REQ-013 SHALL have port err_code  out  3: code of the first violation.
REQ-014 SHALL have port rfs_count  out  16: count of AUTO_REFRESH commands, wraps.

Function
REQ-015 SHALL decode {nRAS,nCAS,nWE} at each edge with sdram_ncs=0: 111 NOP, 011 ACTIVE, 101 READ, 100 WRITE, 010 PRECHARGE, 001 AUTO_REFRESH, 000 LOAD_MODE, 110 BURST_TERMINATE (treated as NOP); sdram_ncs=1 = NOP.
REQ-016 LOAD_MODE SHALL latch cas_lat = sdram_a[6:4] and set mode_valid; sdram_a[2:0]!=0 (burst length not 1) or cas_lat not 2/3 SHALL raise err code 1.
REQ-017 ACTIVE SHALL open bank sdram_ba, store the row from sdram_a[12:0], and restart that bank's RCD counter.
REQ-018 ACTIVE to an already-open bank SHALL raise err code 2 and replace the stored row.
REQ-019 READ/WRITE SHALL use column sdram_a[8:0] and auto-precharge flag sdram_a[10].
REQ-020 READ/WRITE SHALL form memory index {ba, row[ROW_BITS-1:0], col[COL_BITS-1:0]} into a 2^(2+ROW_BITS+COL_BITS) x 16 store.
REQ-021 READ/WRITE to a closed bank SHALL raise err code 3 and perform no access.
REQ-022 READ/WRITE before mode_valid SHALL raise err code 4 and perform no access.
REQ-023 READ/WRITE fewer than RCD cycles after ACTIVE on the same bank SHALL raise err code 5 and still perform the access.
REQ-024 WRITE sampled at edge N SHALL update the low byte unless sdram_dqml=1 and the high byte unless sdram_dqmh=1, using dq_in sampled at edge N.
REQ-025 READ sampled at edge N SHALL assert dq_oe with the stored word on dq_out from edge N+cas_lat-1 to edge N+cas_lat, then deassert dq_oe; dq_out SHALL hold its value.
REQ-026 Read DQM SHALL be ignored; burst length SHALL be 1.
REQ-027 Reads SHALL be tracked in a per-cycle pipeline so back-to-back READs every cycle each return exactly one word in order.
REQ-028 A WRITE at edge N followed by a READ at edge N+1 to the same index SHALL return the new data.
REQ-029 PRECHARGE SHALL close bank sdram_ba if sdram_a[10]=0 and all banks if sdram_a[10]=1; precharging a closed bank is legal.
REQ-030 Auto-precharge SHALL close the bank on the edge after the READ/WRITE.
REQ-031 AUTO_REFRESH SHALL increment rfs_count; with any bank open it SHALL raise err code 6.
REQ-032 err SHALL be sticky until reset; err_code SHALL hold the first violation; simultaneous violations SHALL report the lowest code.

Reset
REQ-033 reset=1 SHALL clear err, err_code, rfs_count, dq_oe, dq_out, mode_valid and the read pipeline, close all banks, and set cas_lat=3; store contents SHALL be preserved.
REQ-034 reset asserted with reads in flight SHALL cancel them; dq_oe SHALL be 0 on the edge after reset.

Verification
REQ-035 LOAD_MODE a=0x030, ACTIVE ba=1 row=5, 2 NOPs, WRITE col=3 dq=0xBEEF dqm=00, READ col=3 -> dq_oe high and dq_out=0xBEEF exactly 3 edges after READ; err=0.
REQ-036 Write 0xBEEF, then WRITE 0x1234 dqml=1 dqmh=0, then READ -> 0x12EF.
REQ-037 READ with no ACTIVE after LOAD_MODE -> err=1, err_code=3, dq_oe stays 0.
REQ-038 ACTIVE then READ on the next edge (RCD=2) -> err_code=5; data still returned at CL.
REQ-039 CL=2 mode, four READs on consecutive edges to columns 0..3 -> four words on consecutive cycles, in order, first at edge READ0+2.
REQ-040 READ issued, reset pulsed 1 cycle later -> dq_oe=0 throughout; after reset, AUTO_REFRESH x3 -> rfs_count=3, err=0.
